anita_l0_scaler_ctrl: RTL and testbench
=======================================

# anita_l0_scaler_ctrl

Gated scaler controller for the 12 L0 trigger bits (TR, MR, BR, TR, MR, BR, TL, ML, BL, TL, ML, BL order, bits 0–11) in the clk100 domain. It runs a fixed-length counting gate and counts L0 activity per channel with saturating counters. At each gate end it snapshots all 12 counts into a holding bank. It streams that bank to the housekeeping/readout logic over a valid/ready handshake, one channel per beat.

## Interface
- GATE_CYCLES, 100000000, gate length in clk100_i cycles (1 s); legal range 2..2^32-1
- CNT_WIDTH, 16, per-channel counter and bank word width
- clk100_i  in  1  system clock, 100 MHz; all logic on its rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- l0_i  in  12  L0 bits, synchronous to clk100_i, in scaler bus order
- enable_i  in  1  counting enable
- gate_o  out  1  one-cycle pulse on the last cycle of each gate
- new_o  out  1  one-cycle pulse: bank updated
- rd_start_i  in  1  request to stream the bank
- rd_ready_i  in  1  consumer ready
- rd_valid_o  out  1  beat valid
- rd_chan_o  out  4  channel index of the current beat, 0..11
- rd_data_o  out  CNT_WIDTH  bank word for rd_chan_o
- rd_last_o  out  1  high with the channel-11 beat
- busy_o  out  1  streaming in progress
- overrun_o  out  1  sticky flag: a gate ended during streaming

## Operation
- Gate timer: 32-bit counter, 0..GATE_CYCLES-1. gate_o is high when the timer equals GATE_CYCLES-1; the timer then wraps to 0.
- enable_i low: the timer and all 12 counters are held at 0; no gate_o. Readout is unaffected.
- Counters: each channel adds its hit (0/1) every cycle. Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Gate end (gate_o cycle):
  - The snapshot value is counter + that cycle's hit, saturated.
  - All counters restart at 0. The next cycle's hit counts toward the new gate.
- Bank update:
  - FSM in IDLE at gate end: the bank is loaded with the snapshot and new_o pulses.
  - FSM in STREAM at gate end: the snapshot is discarded, the bank is unchanged, new_o stays low, and overrun_o is set.
- FSM states:
  - IDLE. rd_start_i=1 causes a transition to STREAM. rd_chan_o is set to 0 and overrun_o is cleared.
  - STREAM. rd_valid_o=1. Each cycle with rd_valid_o and rd_ready_i both high is a beat. After each beat rd_chan_o increments. The beat on channel 11 returns the FSM to IDLE.
  - rd_start_i is ignored in STREAM.
- rd_data_o = bank[rd_chan_o] (combinational mux of the registered bank). rd_last_o = rd_valid_o && rd_chan_o==11. busy_o = (state==STREAM).
- After reset, the bank holds all zeros. A stream requested before the first gate end therefore returns 12 zero words.
- Simultaneous events:
  - rd_start_i in IDLE on the gate_o cycle: the bank loads and the FSM enters STREAM on the same edge. The stream returns the new snapshot, and overrun_o is not set.
  - The final beat (channel 11) on the gate_o cycle: the FSM is still in STREAM, so the snapshot is dropped and overrun_o is set.

## Timing
- Reset values:
  - outputs gate_o, new_o, rd_valid_o, rd_last_o, busy_o, overrun_o = 0; rd_chan_o = 0; rd_data_o = 0;
  - internal timer and counters = 0; FSM in IDLE.
- Reset mid-stream aborts the stream immediately (asynchronous). The bank is cleared.
- new_o and the bank update occur one cycle after gate_o (registered on the gate_o edge).
- rd_start_i to first rd_valid_o: 1 cycle. With rd_ready_i held high, 12 consecutive beats follow, and busy_o drops the cycle after the last beat.
- rd_chan_o and rd_data_o are stable while rd_valid_o=1 and rd_ready_i=0.

## Configuration
- L0_SCALER_EDGE_EN defined:
  - A hit is a rising edge: l0_i[n] & ~prev[n].
  - prev is a per-bit register that resets to 0. An l0_i bit already high at the first cycle out of reset therefore counts once.
- Undefined: a hit is every cycle with l0_i[n]=1 (a level/occupancy count).

## Test plan
- GATE_CYCLES=20, enable_i=1, l0_i[0] held high in level mode, then stream with rd_ready_i=1:
  - gate_o pulses every 20 cycles;
  - the streamed beats are chan0=20 and chans 1–11=0;
  - rd_last_o is high on the 12th beat only.
- Edge mode, l0_i[5] toggling every cycle for one 20-cycle gate -> bank[5]=10.
- CNT_WIDTH=4, level mode, all bits high for a 20-cycle gate -> all 12 words = 15 (saturated, not 4).
- Streaming with rd_ready_i low for 30 cycles across a gate end:
  - overrun_o=1, no new_o, and the bank is unchanged;
  - the next rd_start_i clears overrun_o.
- rd_start_i coincident with gate_o -> the stream returns the new snapshot and overrun_o stays 0.
- rst_n_i low mid-stream -> all outputs 0 in the same cycle; a stream after reset returns 12 zeros.

Source files
------------

// File: rtl/anita_l0_scaler_ctrl.sv
// Gated L0 scaler: 12 saturating per-channel counters over a fixed gate, a snapshot bank and a
// valid/ready per-channel stream. Define L0_SCALER_EDGE_EN to count rising edges, not levels.
module anita_l0_scaler_ctrl #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk100_i,
    input  logic                 rst_n_i,
    input  logic [11:0]          l0_i,
    input  logic                 enable_i,
    output logic                 gate_o,
    output logic                 new_o,
    input  logic                 rd_start_i,
    input  logic                 rd_ready_i,
    output logic                 rd_valid_o,
    output logic [3:0]           rd_chan_o,
    output logic [CNT_WIDTH-1:0] rd_data_o,
    output logic                 rd_last_o,
    output logic                 busy_o,
    output logic                 overrun_o
);
    localparam logic [31:0]          GateLast = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = {CNT_WIDTH{1'b1}};
    localparam logic [3:0]           LastChan = 4'd11;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e               state_q, state_d;
    logic [31:0]          timer_q;
    logic [CNT_WIDTH-1:0] cnt_q  [12];
    logic [CNT_WIDTH-1:0] snap   [12];
    logic [CNT_WIDTH-1:0] bank_q [12];
    logic [3:0]           chan_q, chan_d;
    logic                 new_q;
    logic                 overrun_q, overrun_d;
    logic [11:0]          hit;
    logic                 gate_end;
    logic                 bank_load;

`ifdef L0_SCALER_EDGE_EN
    logic [11:0] prev_q;

    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) prev_q <= '0;
        else          prev_q <= l0_i;
    end

    assign hit = l0_i & ~prev_q;
`else
    assign hit = l0_i;
`endif

    assign gate_end  = enable_i && (timer_q == GateLast);
    // A gate ending mid-stream must not disturb the words being read out.
    assign bank_load = gate_end && (state_q == StIdle);

    always_comb begin
        for (int n = 0; n < 12; n++) begin
            snap[n] = (cnt_q[n] == CntMax) ? CntMax : cnt_q[n] + CNT_WIDTH'(hit[n]);
        end
    end

    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_q <= '0;
            for (int n = 0; n < 12; n++) cnt_q[n] <= '0;
        end else if (!enable_i || gate_end) begin
            timer_q <= '0;
            for (int n = 0; n < 12; n++) cnt_q[n] <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
            for (int n = 0; n < 12; n++) cnt_q[n] <= snap[n];
        end
    end

    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < 12; n++) bank_q[n] <= '0;
            new_q <= 1'b0;
        end else begin
            if (bank_load) begin
                for (int n = 0; n < 12; n++) bank_q[n] <= snap[n];
            end
            new_q <= bank_load;
        end
    end

    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            chan_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (rd_start_i) begin
                    state_d   = StStream;
                    chan_d    = '0;
                    overrun_d = 1'b0;
                end
            end
            StStream: begin
                if (gate_end) overrun_d = 1'b1;
                if (rd_ready_i) begin
                    // Park the index at 0 so the idle mux never selects past channel 11.
                    if (chan_q == LastChan) begin
                        state_d = StIdle;
                        chan_d  = '0;
                    end else begin
                        chan_d = chan_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gate_o     = gate_end;
    assign new_o      = new_q;
    assign rd_valid_o = (state_q == StStream);
    assign rd_chan_o  = chan_q;
    assign rd_data_o  = bank_q[chan_q];
    assign rd_last_o  = rd_valid_o && (chan_q == LastChan);
    assign busy_o     = (state_q == StStream);
    assign overrun_o  = overrun_q;
endmodule

// File: tb/tb_anita_l0_scaler_ctrl.sv
// Bench for anita_l0_scaler_ctrl: two instances (16-bit and 4-bit counters) share stimulus and
// are compared every cycle against a count-and-snapshot reference model.
module tb_anita_l0_scaler_ctrl;
    localparam int unsigned G = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] l0;
    logic        enable, rd_start, rd_ready;

    logic        gate_a, new_a, valid_a, last_a, busy_a, ovr_a;
    logic [3:0]  chan_a;
    logic [15:0] data_a;
    logic        gate_b, new_b, valid_b, last_b, busy_b, ovr_b;
    logic [3:0]  chan_b;
    logic [3:0]  data_b;

    always #5 clk = ~clk;

    anita_l0_scaler_ctrl #(.GATE_CYCLES(G), .CNT_WIDTH(16)) u_dut (
        .clk100_i(clk), .rst_n_i(rst_n), .l0_i(l0), .enable_i(enable),
        .gate_o(gate_a), .new_o(new_a), .rd_start_i(rd_start), .rd_ready_i(rd_ready),
        .rd_valid_o(valid_a), .rd_chan_o(chan_a), .rd_data_o(data_a), .rd_last_o(last_a),
        .busy_o(busy_a), .overrun_o(ovr_a)
    );

    anita_l0_scaler_ctrl #(.GATE_CYCLES(G), .CNT_WIDTH(4)) u_dut_sat (
        .clk100_i(clk), .rst_n_i(rst_n), .l0_i(l0), .enable_i(enable),
        .gate_o(gate_b), .new_o(new_b), .rd_start_i(rd_start), .rd_ready_i(rd_ready),
        .rd_valid_o(valid_b), .rd_chan_o(chan_b), .rd_data_o(data_b), .rd_last_o(last_b),
        .busy_o(busy_b), .overrun_o(ovr_b)
    );

    // Reference model: raw (unsaturated) hit counts; saturation applied when compared.
    int unsigned tcount;
    int unsigned acc [12];
    int unsigned bank_raw [12];
    bit          streaming;
    int unsigned beat;
    bit          overrun_m, new_m;
    logic [11:0] prev_m;

    int vectors = 0;
    int errors  = 0;

    function automatic int unsigned sat(int unsigned v, int unsigned w);
        int unsigned mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tcount = 0; streaming = 0; beat = 0; overrun_m = 0; new_m = 0; prev_m = '0;
        for (int n = 0; n < 12; n++) begin
            acc[n] = 0;
            bank_raw[n] = 0;
        end
    endtask

    task automatic check_outputs();
        logic        eg;
        int unsigned ec;
        eg = enable && (tcount == G - 1);
        ec = streaming ? beat : 0;
        chk("a.gate", 32'(gate_a), 32'(eg));
        chk("a.new", 32'(new_a), 32'(new_m));
        chk("a.valid", 32'(valid_a), 32'(streaming));
        chk("a.chan", 32'(chan_a), ec);
        chk("a.data", 32'(data_a), sat(bank_raw[ec], 16));
        chk("a.last", 32'(last_a), 32'(streaming && beat == 11));
        chk("a.busy", 32'(busy_a), 32'(streaming));
        chk("a.overrun", 32'(ovr_a), 32'(overrun_m));
        chk("b.gate", 32'(gate_b), 32'(eg));
        chk("b.new", 32'(new_b), 32'(new_m));
        chk("b.chan", 32'(chan_b), ec);
        chk("b.data", 32'(data_b), sat(bank_raw[ec], 4));
        chk("b.last", 32'(last_b), 32'(streaming && beat == 11));
        chk("b.overrun", 32'(ovr_b), 32'(overrun_m));
    endtask

    task automatic model_edge();
        logic [11:0] hit;
        bit          gate, was_streaming;
`ifdef L0_SCALER_EDGE_EN
        hit = l0 & ~prev_m;
`else
        hit = l0;
`endif
        prev_m = l0;
        gate = enable && (tcount == G - 1);
        was_streaming = streaming;
        new_m = gate && !was_streaming;
        if (gate) begin
            if (!was_streaming) begin
                for (int n = 0; n < 12; n++) bank_raw[n] = acc[n] + hit[n];
            end else begin
                overrun_m = 1;
            end
        end
        if (!enable || gate) begin
            tcount = 0;
            for (int n = 0; n < 12; n++) acc[n] = 0;
        end else begin
            tcount++;
            for (int n = 0; n < 12; n++) acc[n] += hit[n];
        end
        if (!was_streaming) begin
            if (rd_start) begin
                streaming = 1; beat = 0; overrun_m = 0;
            end
        end else if (rd_ready) begin
            if (beat == 11) begin
                streaming = 0; beat = 0;
            end else begin
                beat++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic stream_all(bit random_ready);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        cycle();
        rd_start = 1'b0;
        for (int i = 0; i < 100 && streaming; i++) begin
            rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
        end
        chk("stream.done", 32'(busy_a), 32'd0);
        rd_ready = 1'b0;
    endtask

    task automatic wait_gate_cycle();
        for (int i = 0; i < 2 * G && !(enable && tcount == G - 1); i++) cycle();
        chk("gate.reached", 32'(gate_a), 32'd1);
    endtask

    initial begin
        l0 = '0; enable = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        do_reset();

        // Stream before any gate end: 12 zero words.
        stream_all(1'b0);

        // Level counting on channel 0 over two gates.
        enable = 1'b1;
        l0 = 12'h001;
        repeat (45) cycle();
        chk("lvl.bank0.a", 32'(data_a), 32'd20);
        chk("lvl.bank0.b", 32'(data_b), 32'd15);
        stream_all(1'b0);

        // All channels high for a full gate: 4-bit instance saturates at 15.
        l0 = 12'hFFF;
        wait_gate_cycle();
        cycle();
        wait_gate_cycle();
        cycle();
        chk("sat.bank0.b", 32'(data_b), 32'd15);
        stream_all(1'b0);

        // Channel 5 toggling every cycle for a gate: 10 hits.
        l0 = 12'h000;
        wait_gate_cycle();
        cycle();
        for (int i = 0; i < G; i++) begin
            l0 = (i % 2 == 0) ? 12'h020 : 12'h000;
            cycle();
        end
        l0 = 12'h000;
        stream_all(1'b0);

        // Stalled stream across a gate end sets overrun; the next start clears it.
        l0 = 12'h0A5;
        rd_ready = 1'b0;
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        repeat (30) cycle();
        chk("ovr.flag", 32'(ovr_a), 32'd1);
        chk("ovr.busy", 32'(busy_a), 32'd1);
        rd_ready = 1'b1;
        repeat (12) cycle();
        chk("ovr.idle", 32'(busy_a), 32'd0);
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        chk("ovr.clear", 32'(ovr_a), 32'd0);
        for (int i = 0; i < 20 && streaming; i++) cycle();

        // Start coincident with gate end: stream returns the fresh snapshot.
        l0 = 12'($urandom);
        wait_gate_cycle();
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        chk("coin.overrun", 32'(ovr_a), 32'd0);
        chk("coin.new", 32'(new_a), 32'd1);
        for (int i = 0; i < 20 && streaming; i++) cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            l0       = 12'($urandom);
            enable   = ($urandom_range(0, 31) != 0);
            rd_ready = 1'($urandom_range(0, 1));
            rd_start = ($urandom_range(0, 7) == 0);
            cycle();
        end
        rd_start = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 100 && streaming; i++) begin
            rd_ready = 1'b1;
            cycle();
        end

        // Reset in the middle of a stream, then a stream of zeros.
        l0 = 12'hFFF;
        wait_gate_cycle();
        cycle();
        rd_ready = 1'b1;
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        repeat (3) cycle();
        do_reset();
        chk("rst.busy", 32'(busy_a), 32'd0);
        stream_all(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
